// File: rtl/vdp_bg_tile_fetch_pkg.sv
// vdp_bg_tile_fetch_pkg: name-table geometry and entry bit positions for the Mode-4 background fetcher
package vdp_bg_tile_fetch_pkg;
  localparam int NT_COLS = 32;
  localparam int NT_ROWS = 28;
  localparam int PAT_HI  = 0;
  localparam int HFLIP   = 1;
  localparam int VFLIP   = 2;
  localparam int PAL     = 3;
endpackage

// File: rtl/vdp_tile_addr_gen.sv
// vdp_tile_addr_gen: maps tile phase, fetch column/line and the staged entry to a VRAM byte address
module vdp_tile_addr_gen
  import vdp_bg_tile_fetch_pkg::*;
(
  input  logic [2:0]  phase,
  input  logic [4:0]  col,
  input  logic [9:0]  ln,
  input  logic [7:0]  nt_lo,
  input  logic [7:0]  nt_hi,
  input  logic [13:0] base,
  output logic [13:0] vram_a
);
  logic [4:0]  row;
  logic [2:0]  vrow;
  logic [1:0]  k;
  logic [13:0] nt_a;
  logic [13:0] pat_a;
  always_comb begin
    row    = ln[7:3] >= 5'(NT_ROWS) ? ln[7:3] - 5'(NT_ROWS) : ln[7:3];
    vrow   = nt_hi[VFLIP] ? ~ln[2:0] : ln[2:0];
    // phase 7 keeps presenting the plane-3 address
    k      = phase == 3'd7 ? 2'd3 : 2'(phase - 3'd3);
    nt_a   = base + 14'({row, col, phase != 3'd0});
    pat_a  = {nt_hi[PAT_HI], nt_lo, vrow, k};
    vram_a = phase < 3'd3 ? nt_a : pat_a;
  end
endmodule

// File: rtl/vdp_bg_tile_fetch.sv
// vdp_bg_tile_fetch: fetches the next tile's entry and planes while the current tile is shifted out
module vdp_bg_tile_fetch
  import vdp_bg_tile_fetch_pkg::*;
#(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [13:0] name_table_addr,
  output logic [13:0] vram_a,
  input  logic [7:0]  vram_d,
  output logic [4:0]  color
);
  logic [2:0]       phase;
  logic             wrap;
  logic [4:0]       col;
  logic [9:0]       ln;
  logic [2:0]       bit_i;
  logic [3:0]       pixel;
  logic [7:0]       nt_lo_q, nt_lo_d, nt_hi_q, nt_hi_d;
  logic [2:0][7:0]  pl_q, pl_d;
  logic [3:0][7:0]  cur_q, cur_d;
  logic             hflip_q, hflip_d, pal_q, pal_d;
  logic [4:0]       color_q, color_d;
  always_comb begin
    phase = x[2:0];
    wrap  = x >= 10'(H_TOTAL - 8);
    col   = wrap ? 5'd0 : x[7:3] + 5'd1;
    ln    = wrap ? (y == 10'(V_TOTAL - 1) ? 10'd0 : y + 10'd1) : y;
  end
  vdp_tile_addr_gen u_addr (
    .phase  (phase),
    .col    (col),
    .ln     (ln),
    .nt_lo  (nt_lo_q),
    .nt_hi  (nt_hi_q),
    .base   (name_table_addr),
    .vram_a (vram_a)
  );
  // vram_d carries the data for the address presented one phase earlier
  always_comb begin
    nt_lo_d  = phase == 3'd1 ? vram_d : nt_lo_q;
    nt_hi_d  = phase == 3'd2 ? vram_d : nt_hi_q;
    pl_d[0]  = phase == 3'd4 ? vram_d : pl_q[0];
    pl_d[1]  = phase == 3'd5 ? vram_d : pl_q[1];
    pl_d[2]  = phase == 3'd6 ? vram_d : pl_q[2];
    cur_d    = phase == 3'd7 ? {vram_d, pl_q[2], pl_q[1], pl_q[0]} : cur_q;
    hflip_d  = phase == 3'd7 ? nt_hi_q[HFLIP] : hflip_q;
    pal_d    = phase == 3'd7 ? nt_hi_q[PAL] : pal_q;
    bit_i    = hflip_q ? phase : ~phase;
    pixel    = {cur_q[3][bit_i], cur_q[2][bit_i], cur_q[1][bit_i], cur_q[0][bit_i]};
    color_d  = {pal_q, pixel};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      nt_lo_q <= '0;
      nt_hi_q <= '0;
      pl_q    <= '0;
      cur_q   <= '0;
      hflip_q <= 1'b0;
      pal_q   <= 1'b0;
      color_q <= '0;
    end else begin
      nt_lo_q <= nt_lo_d;
      nt_hi_q <= nt_hi_d;
      pl_q    <= pl_d;
      cur_q   <= cur_d;
      hflip_q <= hflip_d;
      pal_q   <= pal_d;
      color_q <= color_d;
    end
  assign color = color_q;
endmodule

// File: tb/tb_vdp_bg_tile_fetch.sv
// tb_vdp_bg_tile_fetch: directed vectors against a synchronous VRAM model with hand-computed addresses and colours
module tb_vdp_bg_tile_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  x = '0;
  logic [9:0]  y = '0;
  logic [13:0] name_table_addr = 14'h3800;
  logic [13:0] vram_a;
  logic [7:0]  vram_d;
  logic [4:0]  color;
  logic [7:0]  mem [0:16383];
  int checks = 0;
  int errors = 0;

  vdp_bg_tile_fetch dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .x               (x),
    .y               (y),
    .name_table_addr (name_table_addr),
    .vram_a          (vram_a),
    .vram_d          (vram_d),
    .color           (color)
  );

  always #5 clk = ~clk;
  always @(posedge clk) vram_d <= rst_n ? mem[vram_a] : 8'($urandom);

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [9:0] nx, input logic [9:0] ny, output logic [13:0] a);
    x = nx;
    y = ny;
    #1 a = vram_a;
    @(posedge clk);
    #1;
  endtask

  logic [13:0] a;
  logic [13:0] seq_a [8] = '{14'h3800, 14'h3801, 14'h3801, 14'h0020, 14'h0021, 14'h0022, 14'h0023, 14'h0023};
  logic [4:0]  line0_c [24] = '{5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01,
                                5'h12, 5'h12, 5'h12, 5'h12, 5'h11, 5'h11, 5'h11, 5'h11,
                                5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h01};

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    mem[14'h3800] = 8'h01; mem[14'h3801] = 8'h00;
    mem[14'h3802] = 8'h00; mem[14'h3803] = 8'h09;
    mem[14'h3804] = 8'h02; mem[14'h3805] = 8'h02;
    mem[14'h3806] = 8'h03; mem[14'h3807] = 8'h04;
    mem[14'h0020] = 8'hFF;
    mem[14'h2000] = 8'h0F; mem[14'h2001] = 8'hF0;
    mem[14'h0040] = 8'h80;
    mem[14'h0074] = 8'hAA;
    x = 10'd3;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_color", 16'(color), 16'h0000);
    chk("rst_vram_a", 16'(vram_a), 16'h0000);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step(10'(784 + i), 10'd524, a);
      if (i >= 8) chk($sformatf("prefetch_a%0d", i - 8), 16'(a), 16'(seq_a[i - 8]));
    end
    for (int i = 0; i < 24; i++) begin
      step(10'(i), 10'd0, a);
      chk($sformatf("line0_c%0d", i), 16'(color), 16'(line0_c[i]));
      if (i == 0)  chk("nt_col1", 16'(a), 16'h3802);
      if (i == 3)  chk("pat_hi_a", 16'(a), 16'h2000);
      if (i == 8)  chk("nt_col2", 16'(a), 16'h3804);
      if (i == 11) chk("pat2_a", 16'(a), 16'h0040);
    end
    for (int i = 16; i < 32; i++) begin
      step(10'(i), 10'd2, a);
      if (i == 19) chk("vflip_a", 16'(a), 16'h0074);
      if (i >= 24) chk($sformatf("vflip_c%0d", i), 16'(color), (i % 2 == 0) ? 16'h0001 : 16'h0000);
    end
    step(10'd792, 10'd7, a);   chk("wrap_lo", 16'(a), 16'h3840);
    step(10'd793, 10'd7, a);   chk("wrap_hi", 16'(a), 16'h3841);
    step(10'd794, 10'd7, a);   chk("wrap_idle", 16'(a), 16'h3841);
    step(10'd0, 10'd223, a);   chk("row27", 16'(a), 16'h3EC2);
    step(10'd0, 10'd224, a);   chk("row28_mod", 16'(a), 16'h3802);
    step(10'd792, 10'd231, a); chk("row29_wrap", 16'(a), 16'h3840);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
